mux_arb: RTL and testbench
==========================

MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001: Parameter WIDTH, default 16, SHALL set the data bits per channel.
REQ-002: Parameter CHANNELS, default 4, legal range 2..16, SHALL set the number of input channels.
REQ-003: Parameter SEL_W, default 2, equal to ceil(log2(CHANNELS)), SHALL set the width of the channel index.
REQ-004: Parameter MODE, default 0, SHALL select arbitration: 0 = external select, 1 = round-robin.
REQ-005: The block SHALL use one clock; reset is synchronous and active-high.
REQ-006: clk  in  1  the single clock; all state updates on its rising edge.
REQ-007: rst  in  1  synchronous active-high reset.
REQ-008: select  in  SEL_W  channel index, used only when MODE=0.
REQ-009: in_data  in  CHANNELS*WIDTH  packed inputs; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010: in_valid  in  CHANNELS  per-channel data-valid.
REQ-011: in_ready  out  CHANNELS  per-channel accept; at most one bit set per cycle.
REQ-012: out_data  out  WIDTH  registered output data.
REQ-013: out_valid  out  1  out_data holds an unconsumed word.
REQ-014: out_ready  in  1  downstream accepts the output word.
REQ-015: out_chan  out  SEL_W  index of the channel that sourced out_data.

Function
REQ-016: The output stage SHALL be a single-entry register, states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017: A transfer on channel i SHALL occur when in_valid[i] and in_ready[i] are both 1 at a rising edge.
REQ-018: An output transfer SHALL occur when out_valid and out_ready are both 1 at a rising edge.
REQ-019: The register SHALL be loadable when EMPTY, or when FULL with out_ready=1, so back-to-back streaming runs at one word per cycle.
REQ-020: in_ready SHALL be combinational from the current state, select, in_valid, out_ready and the round-robin pointer, and 0 on all channels when the register is not loadable.
REQ-021: In MODE=0, in_ready[select] SHALL equal loadable, and all other in_ready bits SHALL be 0.
REQ-022: In MODE=0, a select value >= CHANNELS SHALL grant no channel.
REQ-023: In MODE=1, the grant SHALL go to the first channel with in_valid=1, searching upward from the pointer ptr and wrapping from CHANNELS-1 to 0.
REQ-024: In MODE=1, no grant SHALL be issued when no in_valid bit is set.
REQ-025: In MODE=1, ptr SHALL become (granted index + 1) mod CHANNELS after each input transfer, and hold otherwise.
REQ-026: On an input transfer, out_data SHALL take the granted channel word, out_chan its index, and out_valid 1, all with latency one clock.
REQ-027: On an output transfer without a simultaneous input transfer, out_valid SHALL become 0, and out_data and out_chan SHALL hold their values.
REQ-028: When FULL and out_ready=0, out_data, out_chan and out_valid SHALL hold (backpressure), and no in_ready bit SHALL be set.
REQ-029: A change of select while FULL SHALL not alter the held word.
REQ-030: Deasserting in_valid without a transfer SHALL have no effect on state.

Reset
REQ-031: With rst=1 at a rising edge, out_valid SHALL become 0, out_data all zeros, out_chan 0, and ptr 0.
REQ-032: While rst=1, all in_ready bits SHALL be 0.
REQ-033: Reset mid-transfer SHALL discard the held word, and no transfer SHALL be counted in the reset cycle.
REQ-034: The first cycle after rst falls SHALL behave as EMPTY.

Verification
REQ-035: Reset, then MODE=0, select=2, in_data words 11111/22222/33333/44444, all valid, out_ready=1 -> from cycle 2 onward, out_data=33333 and out_chan=2 every cycle, with in_ready=4'b0100.
REQ-036: MODE=0, select increments every cycle, all valid, out_ready=1 -> out_data sequence 11111, 22222, 33333, 44444, 11111..., each one cycle after its select value.
REQ-037: MODE=0, register FULL holding 22222, out_ready=0 for 5 cycles while select changes -> out_data stays 22222, in_ready=0; first cycle out_ready=1 -> next word loads the same cycle.
REQ-038: MODE=1, all four channels valid, out_ready=1 -> out_chan sequence 0,1,2,3,0 with ptr wrapping; then only in_valid[1]=1 -> out_chan=1 every cycle.
REQ-039: MODE=1, in_valid=4'b1001 and ptr=1 -> grant to channel 3, next ptr=0, next grant to channel 0.
REQ-040: rst asserted while FULL with out_ready=0 -> next cycle out_valid=0, out_data=0, ptr=0, in_ready=0.

Source files
------------

// File: rtl/mux_arb.sv
// Multi-channel input mux with a single-entry registered output stage.
// Channel choice is either an external select (MODE=0) or round-robin (MODE=1).
module mux_arb #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned MODE     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SEL_W-1:0]          select,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StFull  = 1'b1;

  localparam logic [SEL_W:0]   ChanCnt = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(CHANNELS - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [WIDTH-1:0] chan_data [CHANNELS];
  logic             loadable;
  logic             sel_ok;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W:0]   cand;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic             in_xfer;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Loadable when empty, or when the held word leaves this same edge.
  assign loadable = !rst && ((state_q == StEmpty) || out_ready);
  assign sel_ok   = ({1'b0, select} < ChanCnt);

  // First valid channel at or above ptr_q, wrapping past the last channel.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    cand   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand = {1'b0, ptr_q} + (SEL_W+1)'(k);
      if (cand >= ChanCnt) cand = cand - ChanCnt;
      if (!rr_vld && in_valid[cand[SEL_W-1:0]]) begin
        rr_vld = 1'b1;
        rr_idx = cand[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    if (MODE == 1) begin
      grant_vld = rr_vld;
      grant_idx = rr_idx;
    end else begin
      grant_vld = sel_ok;
      grant_idx = select;
    end
  end

  always_comb begin
    in_ready = '0;
    if (loadable && grant_vld) in_ready[grant_idx] = 1'b1;
  end

  assign in_xfer = |(in_ready & in_valid);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    if (in_xfer) begin
      state_d = StFull;
      data_d  = chan_data[grant_idx];
      chan_d  = grant_idx;
      if (MODE == 1) ptr_d = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
    end else if ((state_q == StFull) && out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_chan  = chan_q;

endmodule

// File: tb/tb_mux_arb.sv
// Directed bench for mux_arb: one instance per arbitration mode, shared clock/reset/data.
module tb_mux_arb;

  localparam int unsigned W = 16;
  localparam int unsigned C = 4;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [C*W-1:0] in_data;
  logic [W-1:0] words [C];

  logic [S-1:0] sel0, sel1;
  logic [C-1:0] valid0, valid1, rdy0, rdy1;
  logic [W-1:0] data0, data1;
  logic         ov0, ov1, ordy0, ordy1;
  logic [S-1:0] chan0, chan1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_arb #(.WIDTH(W), .CHANNELS(C), .SEL_W(S), .MODE(0)) u_ext (
    .clk(clk), .rst(rst), .select(sel0), .in_data(in_data), .in_valid(valid0),
    .in_ready(rdy0), .out_data(data0), .out_valid(ov0), .out_ready(ordy0), .out_chan(chan0)
  );

  mux_arb #(.WIDTH(W), .CHANNELS(C), .SEL_W(S), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .select(sel1), .in_data(in_data), .in_valid(valid1),
    .in_ready(rdy1), .out_data(data1), .out_valid(ov1), .out_ready(ordy1), .out_chan(chan1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    words[0] = 16'd11111;
    words[1] = 16'd22222;
    words[2] = 16'd33333;
    words[3] = 16'd44444;
    in_data = {words[3], words[2], words[1], words[0]};
    rst = 1'b1; sel0 = 2'd0; sel1 = 2'd0;
    valid0 = 4'hF; valid1 = 4'hF; ordy0 = 1'b1; ordy1 = 1'b1;

    // Reset state and no grants while in reset
    #1;
    chk("rst_rdy0", 32'(rdy0), 32'h0);
    chk("rst_rdy1", 32'(rdy1), 32'h0);
    tick();
    chk("rst_ov0", 32'(ov0), 32'd0);
    chk("rst_data0", 32'(data0), 32'd0);
    chk("rst_chan0", 32'(chan0), 32'd0);
    chk("rst_ov1", 32'(ov1), 32'd0);

    // Fixed select=2 streaming
    valid1 = 4'h0;
    rst = 1'b0; sel0 = 2'd2;
    #1;
    chk("sel2_rdy_empty", 32'(rdy0), 32'b0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sel2_data", 32'(data0), 32'd33333);
      chk("sel2_chan", 32'(chan0), 32'd2);
      chk("sel2_ov", 32'(ov0), 32'd1);
      chk("sel2_rdy", 32'(rdy0), 32'b0100);
    end

    // Incrementing select, one word per cycle
    for (int i = 0; i < 6; i++) begin
      s = i % 4;
      sel0 = 2'(s);
      #1;
      chk("inc_rdy", 32'(rdy0), 32'(1 << s));
      tick();
      chk("inc_data", 32'(data0), 32'(words[s]));
      chk("inc_chan", 32'(chan0), 32'(s));
    end

    // Backpressure while holding 22222
    sel0 = 2'd1;
    tick();
    chk("bp_load", 32'(data0), 32'd22222);
    ordy0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sel0 = 2'((i + 2) % 4);
      #1;
      chk("bp_rdy", 32'(rdy0), 32'h0);
      tick();
      chk("bp_data", 32'(data0), 32'd22222);
      chk("bp_chan", 32'(chan0), 32'd1);
      chk("bp_ov", 32'(ov0), 32'd1);
    end
    ordy0 = 1'b1; sel0 = 2'd3;
    #1;
    chk("bp_release_rdy", 32'(rdy0), 32'b1000);
    tick();
    chk("bp_release_data", 32'(data0), 32'd44444);
    chk("bp_release_chan", 32'(chan0), 32'd3);

    // Drain without refill, then idle with valid low
    valid0 = 4'h0;
    tick();
    chk("drain_ov", 32'(ov0), 32'd0);
    chk("drain_data", 32'(data0), 32'd44444);
    chk("drain_chan", 32'(chan0), 32'd3);
    sel0 = 2'd0;
    tick();
    chk("idle_ov", 32'(ov0), 32'd0);
    chk("idle_data", 32'(data0), 32'd44444);

    // Round-robin over all four channels
    valid1 = 4'hF; ordy1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s = i % 4;
      #1;
      chk("rr_rdy", 32'(rdy1), 32'(1 << s));
      tick();
      chk("rr_chan", 32'(chan1), 32'(s));
      chk("rr_data", 32'(data1), 32'(words[s]));
    end
    // ptr now 1; only channel 1 requests
    valid1 = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rr_one_rdy", 32'(rdy1), 32'b0010);
      tick();
      chk("rr_one_chan", 32'(chan1), 32'd1);
    end
    // ptr now 2; channel 0 alone brings ptr to 1
    valid1 = 4'b0001;
    tick();
    chk("rr_c0_chan", 32'(chan1), 32'd0);
    valid1 = 4'b1001;
    #1;
    chk("rr_wrap_rdy", 32'(rdy1), 32'b1000);
    tick();
    chk("rr_wrap_chan", 32'(chan1), 32'd3);
    chk("rr_next_rdy", 32'(rdy1), 32'b0001);
    tick();
    chk("rr_next_chan", 32'(chan1), 32'd0);

    // No requests, no grant; word drains
    valid1 = 4'h0;
    #1;
    chk("rr_none_rdy", 32'(rdy1), 32'h0);
    tick();
    chk("rr_none_ov", 32'(ov1), 32'd0);

    // Reset while full and stalled (ptr is 1 here)
    valid1 = 4'hF;
    tick();
    chk("rst_fill_chan", 32'(chan1), 32'd1);
    ordy1 = 1'b0;
    tick();
    chk("rst_stall_ov", 32'(ov1), 32'd1);
    chk("rst_stall_rdy", 32'(rdy1), 32'h0);
    ordy1 = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_mid_rdy1", 32'(rdy1), 32'h0);
    tick();
    chk("rst_mid_ov", 32'(ov1), 32'd0);
    chk("rst_mid_data", 32'(data1), 32'd0);
    chk("rst_mid_chan", 32'(chan1), 32'd0);
    chk("rst_mid_rdy_held", 32'(rdy1), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ptr", 32'(rdy1), 32'b0001);
    tick();
    chk("post_rst_chan", 32'(chan1), 32'd0);
    chk("post_rst_data", 32'(data1), 32'd11111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
